// File: rtl/div_sequential_if.sv
`default_nettype none
// ============================================================================
// Module      : div_sequential_if
// Description : Request/result bundle between the control unit and the divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_sequential_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      start;
    logic [DATA_WIDTH-1:0]     A;
    logic [DATA_WIDTH-1:0]     B;
    logic                      busy;
    logic                      done;
    logic                      div_by_zero;
    logic [2*DATA_WIDTH-1:0]   result;

    modport master (
        output start, A, B,
        input  busy, done, div_by_zero, result
    );

    modport slave (
        input  start, A, B,
        output busy, done, div_by_zero, result
    );
endinterface
`default_nettype wire

// File: rtl/div_sequential.sv
`default_nettype none
// ============================================================================
// Module      : div_sequential
// Description : Restoring shift-subtract signed divider, one quotient bit per
//               clock; result = {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequential #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic          clock,
    input  wire logic          clear_n,
    div_sequential_if.slave    bus
);

    localparam int                  c_CNT_W   = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next;

    logic [c_CNT_W-1:0]         r_count;
    logic [DATA_WIDTH-1:0]      r_rem;
    logic [DATA_WIDTH-1:0]      r_quo;
    logic [DATA_WIDTH-1:0]      r_divisor;
    logic                       r_sign_a;
    logic                       r_sign_b;
    logic                       r_div_by_zero;
    logic [2*DATA_WIDTH-1:0]    r_result;

    logic                       w_b_zero;
    logic [DATA_WIDTH-1:0]      w_abs_a;
    logic [DATA_WIDTH-1:0]      w_abs_b;
    logic [DATA_WIDTH-1:0]      w_rem_sh;
    logic [DATA_WIDTH:0]        w_diff;
    logic                       w_ge;
    logic [DATA_WIDTH-1:0]      w_quo_fix;
    logic [DATA_WIDTH-1:0]      w_rem_fix;

    assign w_b_zero = (bus.B == '0);

    // Magnitudes are taken as unsigned, so the most-negative value maps to 2^(DW-1)
    assign w_abs_a = bus.A[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - bus.A) : bus.A;
    assign w_abs_b = bus.B[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - bus.B) : bus.B;

    // Partial remainder stays below |B| <= 2^(DW-1), so its MSB is always zero before the shift
    assign w_rem_sh = {r_rem[DATA_WIDTH-2:0], r_quo[DATA_WIDTH-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {1'b0, r_divisor};
    assign w_ge     = ~w_diff[DATA_WIDTH];

    assign w_quo_fix = (r_sign_a ^ r_sign_b) ? ({DATA_WIDTH{1'b0}} - r_quo) : r_quo;
    assign w_rem_fix = r_sign_a ? ({DATA_WIDTH{1'b0}} - r_rem) : r_rem;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = w_b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == c_CNT_LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_divisor     <= '0;
            r_sign_a      <= 1'b0;
            r_sign_b      <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_result      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign_a      <= bus.A[DATA_WIDTH-1];
                        r_sign_b      <= bus.B[DATA_WIDTH-1];
                        r_divisor     <= w_abs_b;
                        r_rem         <= '0;
                        r_quo         <= w_abs_a;
                        r_count       <= '0;
                        r_div_by_zero <= w_b_zero;
                        if (w_b_zero) begin
                            r_result <= {bus.A, {DATA_WIDTH{1'b1}}};
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_ge ? w_diff[DATA_WIDTH-1:0] : w_rem_sh;
                    r_quo   <= {r_quo[DATA_WIDTH-2:0], w_ge};
                    r_count <= r_count + c_CNT_ONE;
                end
                S_FIX: begin
                    r_result <= {w_rem_fix, w_quo_fix};
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.result      = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_sequential.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequential
// Description : Scoreboard bench for div_sequential against a 64-bit arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequential;

    localparam int DW = 32;

    typedef struct {
        logic [2*DW-1:0] res;
        logic            dbz;
        int unsigned     issue;
    } exp_t;

    logic            clock;
    logic            clear_n;
    int unsigned     cyc;
    int              checks;
    int              errors;
    exp_t            sbq[$];
    logic [2*DW-1:0] model_res;
    logic            prev_done;

    div_sequential_if #(.DATA_WIDTH(DW)) bus ();

    div_sequential #(.DATA_WIDTH(DW)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic report(input string name, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
        errors++;
        $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: plain signed arithmetic in 64 bits, so MIN/-1 cannot overflow
    function automatic exp_t ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] qv;
        logic [63:0] rv;
        e.issue = 0;
        if (b == '0) begin
            e.res = {a, {DW{1'b1}}};
            e.dbz = 1'b1;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            qv = sa / sb;
            rv = sa % sb;
            e.res = {rv[DW-1:0], qv[DW-1:0]};
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clock) begin
        if (bus.done) begin
            checks++;
            if (prev_done) report("done_width", 64'd2, 64'd1);
            if (sbq.size() == 0) begin
                report("unexpected_done", bus.result, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (bus.result !== e.res) report("result", bus.result, e.res);
                checks++;
                if (bus.div_by_zero !== e.dbz) report("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
                checks++;
                if (cyc - e.issue != (e.dbz ? 0 : DW + 1))
                    report("latency", 64'(cyc - e.issue), 64'(e.dbz ? 0 : DW + 1));
            end
        end
        prev_done = bus.done;
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        int   t;
        t = 0;
        while (bus.busy && t < 100) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (bus.busy) begin
            report("idle_timeout", 64'(bus.busy), 64'd0);
            return;
        end
        e = ref_div(a, b);
        e.issue = cyc + 1;
        sbq.push_back(e);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        checks++;
        if (bus.busy !== 1'b1) report("busy_after_start", 64'(bus.busy), 64'd1);
        checks++;
        if (bus.div_by_zero !== e.dbz) report("dbz_at_start", 64'(bus.div_by_zero), 64'(e.dbz));
        checks++;
        if (bus.result !== (e.dbz ? e.res : model_res))
            report("result_hold", bus.result, e.dbz ? e.res : model_res);
        model_res = e.res;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (sbq.size() != 0) begin
            report("done_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        checks    = 0;
        errors    = 0;
        model_res = '0;
        prev_done = 1'b0;
        clear_n   = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) report("reset_busy", 64'(bus.busy), 64'd0);
        checks++;
        if (bus.done !== 1'b0) report("reset_done", 64'(bus.done), 64'd0);
        checks++;
        if (bus.div_by_zero !== 1'b0) report("reset_dbz", 64'(bus.div_by_zero), 64'd0);
        checks++;
        if (bus.result !== 64'd0) report("reset_result", bus.result, 64'd0);
        clear_n = 1'b1;
        @(negedge clock);

        issue(32'd100, 32'd7);
        issue(32'hFFFFFF9C, 32'd7);
        issue(32'd100, 32'hFFFFFFF9);
        issue(32'h80000000, 32'hFFFFFFFF);
        issue(32'd5, 32'd9);
        issue(32'd7, 32'd0);
        issue(32'd5, 32'd9);
        wait_done();

        // A start pulse in mid-calculation must be ignored
        issue(32'd1000, 32'd3);
        repeat (10) @(negedge clock);
        bus.A     = 32'd1;
        bus.B     = 32'd1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done();

        // Reset mid-operation aborts without producing done
        issue(32'd1000, 32'd3);
        repeat (12) @(negedge clock);
        clear_n = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        void'(sbq.pop_back());
        model_res = '0;
        checks++;
        if (bus.busy !== 1'b0) report("abort_busy", 64'(bus.busy), 64'd0);
        checks++;
        if (bus.done !== 1'b0) report("abort_done", 64'(bus.done), 64'd0);
        checks++;
        if (bus.result !== 64'd0) report("abort_result", bus.result, 64'd0);
        repeat (40) @(negedge clock);
        issue(32'hFFFFFFF7, 32'hFFFFFFFE);
        wait_done();

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: rb = rb >> $urandom_range(0, 31);
                4: ra = 32'h80000000;
                5: ra = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(ra, rb);
        end
        wait_done();

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
